// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
//
// Multi-cycle unsigned shift-and-add multiplier. A single 2*SIZE-bit adder is
// reused over SIZE clock cycles instead of a wide combinational multiplier.
// A start/busy/done handshake sequences the operand registers, the step
// counter and the accumulator.
//
// Ports:
//   Clock    in   1        system clock, rising-edge active
//   Reset    in   1        synchronous, active-low reset
//   iStart   in   1        request, accepted only while IDLE
//   iA       in   SIZE     multiplicand, sampled on the accepting edge
//   iB       in   SIZE     multiplier, sampled on the accepting edge
//   oBusy    out  1        high while an operation is in RUN or DONE
//   oDone    out  1        one-cycle pulse, oResult newly updated
//   oResult  out  2*SIZE   product of the last completed operation
//   oStep    out  clog2    current RUN step index (debug), 0 outside RUN
// ---------------------------------------------------------------------------
module mult_sequencer #(
    parameter int SIZE = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iStart,
    input  logic [SIZE-1:0]           iA,
    input  logic [SIZE-1:0]           iB,
    output logic                      oBusy,
    output logic                      oDone,
    output logic [2*SIZE-1:0]         oResult,
    output logic [$clog2(SIZE)-1:0]   oStep
);

    localparam int STEPW = $clog2(SIZE);
    localparam int RESW  = 2 * SIZE;
    localparam logic [STEPW-1:0] LAST_STEP = STEPW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;

    logic [RESW-1:0]   mcand;
    logic [RESW-1:0]   mcandNext;
    logic [SIZE-1:0]   mplier;
    logic [SIZE-1:0]   mplierNext;
    logic [RESW-1:0]   acc;
    logic [RESW-1:0]   accNext;
    logic [RESW-1:0]   sum;
    logic [STEPW-1:0]  step;
    logic [STEPW-1:0]  stepNext;
    logic [RESW-1:0]   result;
    logic [RESW-1:0]   resultNext;
    logic              busy;
    logic              busyNext;
    logic              done;
    logic              doneNext;

    // Next-state and datapath logic. Every register defaults to holding its
    // value, except the done flag which defaults low so it can only ever be a
    // single-cycle pulse. The step counter is forced back to 0 on the final
    // RUN edge rather than incremented, so it never wraps and oStep reads 0
    // in every state other than RUN.
    always_comb begin
        stateNext  = state;
        mcandNext  = mcand;
        mplierNext = mplier;
        accNext    = acc;
        stepNext   = step;
        resultNext = result;
        busyNext   = busy;
        doneNext   = 1'b0;
        sum        = acc;

        case (state)
            IDLE: begin
                busyNext = 1'b0;
                stepNext = '0;
                if (iStart) begin
                    mcandNext  = {{SIZE{1'b0}}, iA};
                    mplierNext = iB;
                    accNext    = '0;
                    stepNext   = '0;
                    busyNext   = 1'b1;
                    stateNext  = RUN;
                end
            end

            RUN: begin
                // The final result must include this step's addend, so the
                // sum is formed once here and used for both acc and result.
                sum        = mplier[0] ? (acc + mcand) : acc;
                accNext    = sum;
                mcandNext  = mcand << 1;
                mplierNext = mplier >> 1;
                if (step == LAST_STEP) begin
                    resultNext = sum;
                    doneNext   = 1'b1;
                    stepNext   = '0;
                    stateNext  = DONE;
                end else begin
                    stepNext = step + STEPW'(1);
                end
            end

            DONE: begin
                busyNext  = 1'b0;
                stepNext  = '0;
                stateNext = IDLE;
            end

            default: begin
                busyNext  = 1'b0;
                stepNext  = '0;
                stateNext = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over everything, including a
    // start in the same cycle, and aborts any running operation without a
    // done pulse. The stored result is also cleared.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            step   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            mcand  <= mcandNext;
            mplier <= mplierNext;
            acc    <= accNext;
            step   <= stepNext;
            result <= resultNext;
            busy   <= busyNext;
            done   <= doneNext;
        end
    end

    assign oBusy   = busy;
    assign oDone   = done;
    assign oResult = result;
    assign oStep   = step;

endmodule

// File: tb/tb_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_sequencer
//
// Directed bench for mult_sequencer with SIZE=16. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_mult_sequencer;

    localparam int SIZE = 16;

    logic              Clock;
    logic              Reset;
    logic              iStart;
    logic [SIZE-1:0]   iA;
    logic [SIZE-1:0]   iB;
    logic              oBusy;
    logic              oDone;
    logic [2*SIZE-1:0] oResult;
    logic [3:0]        oStep;

    int checks = 0;
    int passes = 0;

    mult_sequencer #(.SIZE(SIZE)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iStart  (iStart),
        .iA      (iA),
        .iB      (iB),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oResult (oResult),
        .oStep   (oStep)
    );

    // Free-running 10-unit clock.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic nextEdge();
        @(posedge Clock);
        #1;
    endtask

    // Drive the request inputs.
    task automatic applyStimulus(input logic start, input logic [SIZE-1:0] a,
                                 input logic [SIZE-1:0] b);
        iStart = start;
        iA     = a;
        iB     = b;
    endtask

    // One comparison: count it, pass or report.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Full operation with a start pulse; operands are scrambled right after
    // the accepting edge to show they are not re-sampled.
    task automatic runOp(input string tag, input logic [SIZE-1:0] a,
                         input logic [SIZE-1:0] b, input logic [31:0] expResult);
        applyStimulus(1'b1, a, b);
        nextEdge();
        applyStimulus(1'b0, 16'hDEAD, 16'hBEEF);
        checkOutput({tag, "-busyAfterStart"}, 64'(oBusy), 64'd1);
        checkOutput({tag, "-step0"}, 64'(oStep), 64'd0);
        checkOutput({tag, "-doneLowStart"}, 64'(oDone), 64'd0);
        for (int j = 1; j < SIZE; j++) begin
            nextEdge();
            checkOutput({tag, "-stepCount"}, 64'(oStep), 64'(j));
            checkOutput({tag, "-doneLowRun"}, 64'(oDone), 64'd0);
        end
        nextEdge();
        checkOutput({tag, "-donePulse"}, 64'(oDone), 64'd1);
        checkOutput({tag, "-result"}, 64'(oResult), 64'(expResult));
        checkOutput({tag, "-busyInDone"}, 64'(oBusy), 64'd1);
        checkOutput({tag, "-stepInDone"}, 64'(oStep), 64'd0);
        nextEdge();
        checkOutput({tag, "-doneCleared"}, 64'(oDone), 64'd0);
        checkOutput({tag, "-busyCleared"}, 64'(oBusy), 64'd0);
        checkOutput({tag, "-resultHeld"}, 64'(oResult), 64'(expResult));
    endtask

    // Directed sequence of tests.
    initial begin
        int doneCount;
        int firstDone;
        int secondDone;

        Reset = 1'b0;
        applyStimulus(1'b1, 16'h0003, 16'h0005);
        nextEdge();
        nextEdge();
        checkOutput("reset-busy", 64'(oBusy), 64'd0);
        checkOutput("reset-done", 64'(oDone), 64'd0);
        Reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        nextEdge();
        checkOutput("reset-result", 64'(oResult), 64'd0);
        checkOutput("reset-step", 64'(oStep), 64'd0);
        checkOutput("idle-busy", 64'(oBusy), 64'd0);

        runOp("mul3x5", 16'h0003, 16'h0005, 32'h0000000F);
        runOp("mulMax", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        runOp("mulZeroA", 16'h0000, 16'h1234, 32'h00000000);
        runOp("mulZeroB", 16'h1234, 16'h0000, 32'h00000000);

        // Start requests during RUN are ignored.
        applyStimulus(1'b1, 16'h0007, 16'h0009);
        nextEdge();
        applyStimulus(1'b0, 16'h0007, 16'h0009);
        repeat (5) nextEdge();
        checkOutput("ignore-step5", 64'(oStep), 64'd5);
        applyStimulus(1'b1, 16'h0002, 16'h0002);
        repeat (3) nextEdge();
        checkOutput("ignore-step8", 64'(oStep), 64'd8);
        applyStimulus(1'b0, 16'h0002, 16'h0002);
        repeat (7) nextEdge();
        checkOutput("ignore-doneLow15", 64'(oDone), 64'd0);
        nextEdge();
        checkOutput("ignore-donePulse", 64'(oDone), 64'd1);
        checkOutput("ignore-result", 64'(oResult), 64'h3F);
        nextEdge();
        checkOutput("ignore-doneLow17", 64'(oDone), 64'd0);
        nextEdge();
        checkOutput("ignore-notQueued", 64'(oBusy), 64'd0);

        // Held start: accepted at edges 0 and 18 (16 RUN edges, one DONE
        // edge, then the first IDLE edge accepts), so done after 16 and 34.
        applyStimulus(1'b1, 16'h00FF, 16'h0100);
        nextEdge();
        doneCount  = 0;
        firstDone  = -1;
        secondDone = -1;
        for (int c = 1; c <= 40; c++) begin
            nextEdge();
            if (oDone) begin
                doneCount++;
                if (firstDone < 0) firstDone = c;
                else if (secondDone < 0) secondDone = c;
                checkOutput("held-result", 64'(oResult), 64'h0000FF00);
            end
        end
        checkOutput("held-firstDone", 64'(firstDone), 64'd16);
        checkOutput("held-secondDone", 64'(secondDone), 64'd34);
        checkOutput("held-doneCount", 64'(doneCount), 64'd2);
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        repeat (20) nextEdge();
        checkOutput("held-idleAfter", 64'(oBusy), 64'd0);

        // Reset in the middle of an operation aborts it.
        applyStimulus(1'b1, 16'h1234, 16'h5678);
        nextEdge();
        applyStimulus(1'b0, 16'h1234, 16'h5678);
        repeat (8) nextEdge();
        checkOutput("abort-step8", 64'(oStep), 64'd8);
        checkOutput("abort-resultHeld", 64'(oResult), 64'h0000FF00);
        Reset = 1'b0;
        nextEdge();
        checkOutput("abort-busy", 64'(oBusy), 64'd0);
        checkOutput("abort-result", 64'(oResult), 64'd0);
        checkOutput("abort-step", 64'(oStep), 64'd0);
        Reset = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 20; c++) begin
            nextEdge();
            if (oDone) doneCount++;
        end
        checkOutput("abort-noDone", 64'(doneCount), 64'd0);
        runOp("restart", 16'h1234, 16'h5678, 32'h06260060);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
